// File: rtl/secuenciador_pkg.sv
// rtl/secuenciador_pkg.sv - shared FSM encoding, default sizes and counter-width helper for the sample sequencer
package secuenciador_pkg;

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CARGA  = 2'd1,
        ESPERA = 2'd2,
        SALIDA = 2'd3
    } estado_t;

    localparam int W_DEF       = 12;
    localparam int DIV_DEF     = 2268;
    localparam int TIMEOUT_DEF = 16;

    // Bits needed to hold 0..div-1.
    function automatic int ancho_contador(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/divisor_muestreo.sv
// rtl/divisor_muestreo.sv - free-running divider producing the one-cycle sample-rate tick
module divisor_muestreo
    import secuenciador_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW     = ancho_contador(DIV);
    localparam logic [CW-1:0] ULTIMO = CW'(DIV - 1);

    logic [CW-1:0] cuenta_q;
    logic [CW-1:0] cuenta_d;

    // Next count: wrap to zero after DIV-1.
    always_comb begin
        cuenta_d = (cuenta_q == ULTIMO) ? '0 : cuenta_q + 1'b1;
    end

    // Count register, runs regardless of what the sequencer is doing.
    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign tick = (cuenta_q == ULTIMO);

endmodule

// File: rtl/secuenciador_muestras.sv
// rtl/secuenciador_muestras.sv - sample sequencer: tick, u(k) latch, datolisto/resultadolisto handshake, y(k) to DAC; SECUENCIADOR_CONTADORES_EN adds saturating overrun/timeout counters
module secuenciador_muestras
    import secuenciador_pkg::*;
#(
    parameter int DIV     = DIV_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] adc_dato,
    input  logic         adc_valido,
    input  logic [W-1:0] y_in,
    input  logic         resultadolisto,
    output logic [W-1:0] u_out,
    output logic         datolisto,
    output logic [W-1:0] dac_dato,
    output logic         dac_valido,
    output logic         ocupado,
    output logic         overrun,
    output logic         error_timeout
`ifdef SECUENCIADOR_CONTADORES_EN
    ,
    output logic [7:0]   cuenta_overrun,
    output logic [7:0]   cuenta_timeout
`endif
);

    // The wait counter starts at zero in the first ESPERA cycle, so it lags
    // the cycles elapsed since datolisto by one; the limit compensates so the
    // error flag becomes visible exactly TIMEOUT cycles after datolisto.
    localparam int                WAIT_W      = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMITE = WAIT_W'(TIMEOUT - 2);

    logic              tick;
    estado_t           estado_q;
    logic [W-1:0]      muestra_q;
    logic [W-1:0]      u_q;
    logic [W-1:0]      dac_q;
    logic              datolisto_q;
    logic              dac_valido_q;
    logic              ocupado_q;
    logic              overrun_q;
    logic              error_q;
    logic [WAIT_W-1:0] espera_q;
    logic              evento_overrun;
    logic              fin_espera;

    divisor_muestreo #(
        .DIV (DIV)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign evento_overrun = tick && (estado_q != REPOSO);
    assign fin_espera     = (espera_q == WAIT_LIMITE);

    // Latest ADC sample; unconsumed samples are simply overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            muestra_q <= '0;
        end else if (adc_valido) begin
            muestra_q <= adc_dato;
        end
    end

    // Handshake sequencer with registered strobes and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= REPOSO;
            u_q          <= '0;
            dac_q        <= '0;
            datolisto_q  <= 1'b0;
            dac_valido_q <= 1'b0;
            ocupado_q    <= 1'b0;
            overrun_q    <= 1'b0;
            error_q      <= 1'b0;
            espera_q     <= '0;
        end else begin
            datolisto_q  <= 1'b0;
            dac_valido_q <= 1'b0;
            overrun_q    <= evento_overrun;
            case (estado_q)
                REPOSO: begin
                    if (tick) begin
                        // A sample arriving with the tick bypasses the register.
                        u_q         <= adc_valido ? adc_dato : muestra_q;
                        datolisto_q <= 1'b1;
                        ocupado_q   <= 1'b1;
                        estado_q    <= CARGA;
                    end
                end
                CARGA: begin
                    espera_q <= '0;
                    estado_q <= ESPERA;
                end
                ESPERA: begin
                    if (resultadolisto) begin
                        dac_q        <= y_in;
                        dac_valido_q <= 1'b1;
                        estado_q     <= SALIDA;
                    end else if (fin_espera) begin
                        error_q   <= 1'b1;
                        ocupado_q <= 1'b0;
                        estado_q  <= REPOSO;
                    end else begin
                        espera_q <= espera_q + 1'b1;
                    end
                end
                SALIDA: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= REPOSO;
                end
                default: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= REPOSO;
                end
            endcase
        end
    end

    assign u_out         = u_q;
    assign datolisto     = datolisto_q;
    assign dac_dato      = dac_q;
    assign dac_valido    = dac_valido_q;
    assign ocupado       = ocupado_q;
    assign overrun       = overrun_q;
    assign error_timeout = error_q;

`ifdef SECUENCIADOR_CONTADORES_EN
    logic [7:0] cuenta_overrun_q;
    logic [7:0] cuenta_timeout_q;
    logic       evento_timeout;

    assign evento_timeout = (estado_q == ESPERA) && !resultadolisto && fin_espera;

    // Event counters that stick at 255 instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta_overrun_q <= '0;
            cuenta_timeout_q <= '0;
        end else begin
            if (evento_overrun && (cuenta_overrun_q != 8'hFF)) begin
                cuenta_overrun_q <= cuenta_overrun_q + 8'd1;
            end
            if (evento_timeout && (cuenta_timeout_q != 8'hFF)) begin
                cuenta_timeout_q <= cuenta_timeout_q + 8'd1;
            end
        end
    end

    assign cuenta_overrun = cuenta_overrun_q;
    assign cuenta_timeout = cuenta_timeout_q;
`endif

endmodule
